// File: rtl/mxfp8_pkg.sv
// Shared constants, the element-format enum and the decoded-lane record
// for the MX FP8 block decoder.
package mxfp8_pkg;

    // Element and output field widths
    localparam int FP8_W      = 8;
    localparam int MANT_W     = 4;   // hidden bit + up to 3 fraction bits
    localparam int CORE_EXP_W = 9;   // holds -141..142, widened at the top

    // Exponent biases
    localparam int E4M3_BIAS  = 7;
    localparam int E5M2_BIAS  = 15;
    localparam int E8M0_BIAS  = 127;

    // E8M0 scale code reserved for NaN
    localparam logic [7:0] E8M0_NAN = 8'hFF;

    typedef enum logic {
        FMT_E4M3 = 1'b0,
        FMT_E5M2 = 1'b1
    } fmt_e;

    typedef struct packed {
        logic                         sign;
        logic signed [CORE_EXP_W-1:0] exp;
        logic [MANT_W-1:0]            mant;
        logic                         zero;
        logic                         nan;
        logic                         inf;
    } lane_t;

endpackage

// File: rtl/mxfp8_lane_decode.sv
// Combinational decode of one FP8 element (E4M3 or E5M2) with the block's
// E8M0 scale folded into the exponent.
module mxfp8_lane_decode
    import mxfp8_pkg::*;
(
    input  logic [FP8_W-1:0] fp8,
    input  fmt_e             mode,
    input  logic [7:0]       scale,
    output lane_t            lane
);

    logic [3:0]                   e4;
    logic [2:0]                   m4;
    logic [4:0]                   e5;
    logic [1:0]                   m5;
    logic signed [CORE_EXP_W-1:0] elem_exp;
    logic signed [CORE_EXP_W-1:0] scale_exp;
    logic [MANT_W-1:0]            mant;
    logic                         is_zero;
    logic                         is_nan;
    logic                         is_inf;

    assign e4 = fp8[6:3];
    assign m4 = fp8[2:0];
    assign e5 = fp8[6:2];
    assign m5 = fp8[1:0];

    // Unbiased scale; 0xFF is caught separately as NaN so the sum never overflows
    assign scale_exp = $signed({1'b0, scale}) - CORE_EXP_W'(E8M0_BIAS);

    // Field extraction and special-value classification for the element
    always_comb begin
        elem_exp = '0;
        mant     = '0;
        is_zero  = 1'b0;
        is_nan   = 1'b0;
        is_inf   = 1'b0;
        if (mode == FMT_E4M3) begin
            // Subnormals share the exponent of the smallest normal
            elem_exp = (e4 == 4'd0) ? CORE_EXP_W'(1 - E4M3_BIAS)
                                    : $signed({5'b0, e4}) - CORE_EXP_W'(E4M3_BIAS);
            mant     = {e4 != 4'd0, m4};
            is_zero  = (e4 == 4'd0) && (m4 == 3'd0);
            // Only all-ones is NaN; E4M3 reuses the top binade for normals
            is_nan   = (e4 == 4'hF) && (m4 == 3'h7);
        end else begin
            elem_exp = (e5 == 5'd0) ? CORE_EXP_W'(1 - E5M2_BIAS)
                                    : $signed({4'b0, e5}) - CORE_EXP_W'(E5M2_BIAS);
            // Two fraction bits left-aligned under the hidden bit
            mant     = {e5 != 5'd0, m5, 1'b0};
            is_zero  = (e5 == 5'd0) && (m5 == 2'd0);
            is_inf   = (e5 == 5'h1F) && (m5 == 2'd0);
            is_nan   = (e5 == 5'h1F) && (m5 != 2'd0);
        end
        if (scale == E8M0_NAN) is_nan = 1'b1;
    end

    // Final lane record: NaN beats Inf beats zero; specials carry no exp/mant
    always_comb begin
        lane      = '0;
        lane.sign = fp8[7];
        if (is_nan) begin
            lane.nan = 1'b1;
        end else if (is_inf) begin
            lane.inf = 1'b1;
        end else if (is_zero) begin
            lane.zero = 1'b1;
        end else begin
            lane.exp  = elem_exp + scale_exp;
            lane.mant = mant;
        end
    end

endmodule

// File: rtl/mxfp8_block_decoder.sv
// Multi-lane MX block decoder: holds one E8M0 scale and element format per
// block, counts beats, decodes LANES elements per beat and registers the
// result behind a valid/ready handshake.
module mxfp8_block_decoder
    import mxfp8_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int BLOCK_SIZE = 32,
    parameter int EXP_W      = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scale_valid,
    output logic                    scale_ready,
    input  logic [7:0]              scale_data,
    input  logic                    scale_mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*FP8_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_sign,
    output logic [LANES*EXP_W-1:0]  out_exp,
    output logic [LANES*MANT_W-1:0] out_mant,
    output logic [LANES-1:0]        out_zero,
    output logic [LANES-1:0]        out_nan,
    output logic [LANES-1:0]        out_inf,
    output logic                    out_last
);

    localparam int BEATS = BLOCK_SIZE / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BEATS - 1);

    if (BLOCK_SIZE % LANES != 0) begin : g_bad_block
        $error("BLOCK_SIZE must be a multiple of LANES");
    end
    if (EXP_W < 9) begin : g_bad_exp
        $error("EXP_W must be at least 9");
    end

    logic             scale_held;
    logic [7:0]       scale_q;
    fmt_e             mode_q;
    logic [CNT_W-1:0] cnt;
    logic             last_beat;
    logic             in_fire;
    logic             scale_fire;
    lane_t            dec [LANES];

    assign last_beat   = (cnt == CNT_MAX);
    assign in_ready    = scale_held & (~out_valid | out_ready);
    assign in_fire     = in_valid & in_ready;
    // Next block's scale may land on the current block's last beat
    assign scale_ready = ~scale_held | (in_fire & last_beat);
    assign scale_fire  = scale_valid & scale_ready;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        mxfp8_lane_decode u_dec (
            .fp8   (in_data[gi*FP8_W +: FP8_W]),
            .mode  (mode_q),
            .scale (scale_q),
            .lane  (dec[gi])
        );
    end

    // Block scale/format register; released after the last beat unless reloaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scale_held <= 1'b0;
            scale_q    <= '0;
            mode_q     <= FMT_E4M3;
        end else if (scale_fire) begin
            scale_held <= 1'b1;
            scale_q    <= scale_data;
            mode_q     <= fmt_e'(scale_mode);
        end else if (in_fire && last_beat) begin
            scale_held <= 1'b0;
        end
    end

    // Beat position within the current block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (in_fire) begin
            cnt <= last_beat ? '0 : cnt + 1'b1;
        end
    end

    // Output register; holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_sign  <= '0;
            out_exp   <= '0;
            out_mant  <= '0;
            out_zero  <= '0;
            out_nan   <= '0;
            out_inf   <= '0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_last  <= last_beat;
            for (int i = 0; i < LANES; i++) begin
                out_sign[i]                  <= dec[i].sign;
                out_exp[i*EXP_W +: EXP_W]    <= EXP_W'(dec[i].exp);
                out_mant[i*MANT_W +: MANT_W] <= dec[i].mant;
                out_zero[i]                  <= dec[i].zero;
                out_nan[i]                   <= dec[i].nan;
                out_inf[i]                   <= dec[i].inf;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mxfp8_block_decoder.sv
// Randomized and directed bench for mxfp8_block_decoder with a queue-based
// scoreboard fed by an integer-arithmetic reference of the MX decode rules.
module tb_mxfp8_block_decoder;

    localparam int L  = 4;
    localparam int BS = 32;
    localparam int EW = 10;
    localparam int NB = BS / L;

    typedef struct {
        logic [L-1:0]    s, z, n, i;
        logic [L*EW-1:0] e;
        logic [L*4-1:0]  m;
        logic            last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            scale_valid, scale_ready, scale_mode;
    logic [7:0]      scale_data;
    logic            in_valid, in_ready;
    logic [L*8-1:0]  in_data;
    logic            out_valid, out_ready, out_last;
    logic [L-1:0]    out_sign, out_zero, out_nan, out_inf;
    logic [L*EW-1:0] out_exp;
    logic [L*4-1:0]  out_mant;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    int bidx = 0;
    bit gaps = 0;
    int bp_mode = 0;          // 0 always ready, 1 random, 2 stalled
    bit sf_q = 0, bf_q = 0;

    logic [8:0]  sq[$];       // scales to offer {mode, scale}
    logic [31:0] bq[$];       // beats to offer
    logic [8:0]  blk_q[$];    // scales accepted, not yet consumed
    beat_t       exq[$];      // expected output beats
    beat_t       got[$];      // observed output beats
    int          fire_cyc[$], sfire_cyc[$], ofire_cyc[$];
    beat_t       g_b, e_b, snap;

    mxfp8_block_decoder #(.LANES(L), .BLOCK_SIZE(BS), .EXP_W(EW)) dut (
        .clk(clk), .rst_n(rst_n),
        .scale_valid(scale_valid), .scale_ready(scale_ready),
        .scale_data(scale_data), .scale_mode(scale_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
        .out_zero(out_zero), .out_nan(out_nan), .out_inf(out_inf),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        nchk++;
        if (got_v !== exp_v) begin
            nerr++;
            $display("FAIL %s got %0h exp %0h", tag, got_v, exp_v);
        end
    endtask

    // Reference decode from the format definitions, in plain integers
    function automatic beat_t ref_beat(logic [L*8-1:0] d, logic md, logic [7:0] sc, logic last);
        beat_t r;
        r.s = '0; r.z = '0; r.n = '0; r.i = '0; r.e = '0; r.m = '0; r.last = last;
        for (int l = 0; l < L; l++) begin
            int b, ef, mf, e, m;
            bit nan, inf, zr;
            b = int'(d[l*8 +: 8]);
            inf = 0;
            if (md == 1'b0) begin
                ef  = (b / 8) % 16;
                mf  = b % 8;
                e   = (ef == 0 ? 1 : ef) - 7;
                m   = (ef != 0 ? 8 : 0) + mf;
                nan = (ef == 15 && mf == 7);
            end else begin
                ef  = (b / 4) % 32;
                mf  = b % 4;
                e   = (ef == 0 ? 1 : ef) - 15;
                m   = (ef != 0 ? 8 : 0) + mf * 2;
                nan = (ef == 31 && mf != 0);
                inf = (ef == 31 && mf == 0);
            end
            zr = (ef == 0 && mf == 0);
            if (sc == 8'hFF) nan = 1;
            if (nan) inf = 0;
            if (nan || inf) begin
                e = 0; m = 0; zr = 0;
            end else if (zr) begin
                e = 0;
            end else begin
                e = e + int'(sc) - 127;
            end
            r.s[l]            = ((b / 128) % 2) != 0;
            r.e[l*EW +: EW]   = EW'(e);
            r.m[l*4 +: 4]     = 4'(m);
            r.z[l]            = zr;
            r.n[l]            = nan;
            r.i[l]            = inf;
        end
        return r;
    endfunction

    function automatic logic [L*EW-1:0] pe(int a, int b, int c, int d);
        logic [L*EW-1:0] r;
        r = {EW'(d), EW'(c), EW'(b), EW'(a)};
        return r;
    endfunction

    // Monitor/scoreboard: handshakes are stable from negedge until the next posedge
    always @(negedge clk) begin
        cyc++;
        sf_q = rst_n && scale_valid && scale_ready;
        bf_q = rst_n && in_valid && in_ready;
        if (!rst_n) begin
            exq.delete();
            blk_q.delete();
            bidx = 0;
        end else begin
            if (out_valid && out_ready) begin
                g_b = '{s: out_sign, z: out_zero, n: out_nan, i: out_inf,
                        e: out_exp, m: out_mant, last: out_last};
                got.push_back(g_b);
                ofire_cyc.push_back(cyc);
                if (exq.size() == 0) begin
                    chk("sb_spurious_beat", 1, 0);
                end else begin
                    e_b = exq.pop_front();
                    chk("sign", g_b.s, e_b.s);
                    chk("exp",  g_b.e, e_b.e);
                    chk("mant", g_b.m, e_b.m);
                    chk("zero", g_b.z, e_b.z);
                    chk("nan",  g_b.n, e_b.n);
                    chk("inf",  g_b.i, e_b.i);
                    chk("last", g_b.last, e_b.last);
                end
            end
            if (bf_q) begin
                fire_cyc.push_back(cyc);
                if (blk_q.size() == 0) begin
                    chk("beat_without_scale", 1, 0);
                end else begin
                    exq.push_back(ref_beat(in_data, blk_q[0][8], blk_q[0][7:0], bidx == NB - 1));
                    if (bidx == NB - 1) begin
                        bidx = 0;
                        blk_q.delete(0);
                    end else begin
                        bidx++;
                    end
                end
            end
            if (sf_q) begin
                blk_q.push_back({scale_mode, scale_data});
                sfire_cyc.push_back(cyc);
            end
        end
    end

    // Driver: offers queued scales/beats, keeps an offer up until accepted
    initial begin
        scale_valid = 0; scale_data = 0; scale_mode = 0;
        in_valid = 0; in_data = 0; out_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            if (sf_q && sq.size() > 0) sq.delete(0);
            if (bf_q && bq.size() > 0) bq.delete(0);
            if (!(scale_valid && !sf_q && sq.size() > 0))
                scale_valid = (sq.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
            if (scale_valid) {scale_mode, scale_data} = sq[0];
            if (!(in_valid && !bf_q && bq.size() > 0))
                in_valid = (bq.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
            if (in_valid) in_data = bq[0];
            out_ready = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic q_blk(input logic [7:0] sc, input logic md, input logic [31:0] b0, input bit rnd);
        sq.push_back({md, sc});
        bq.push_back(b0);
        for (int k = 1; k < NB; k++) bq.push_back(rnd ? $urandom : b0);
    endtask

    task automatic drain(input string tag);
        int c = 0;
        while ((sq.size() > 0 || bq.size() > 0 || exq.size() > 0) && c < 5000) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_drain_timeout"}, c < 5000, 1);
    endtask

    task automatic wait_fires(input int n);
        int c = 0;
        while (fire_cyc.size() < n && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("wait_fires_timeout", c < 200, 1);
    endtask

    task automatic clr_obs();
        got.delete(); fire_cyc.delete(); sfire_cyc.delete(); ofire_cyc.delete();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_exp"}, out_exp, 0);
        chk({tag, "_out_flags"}, {out_sign, out_mant, out_zero, out_nan, out_inf}, 0);
        chk({tag, "_scale_ready"}, scale_ready, 1);
        chk({tag, "_in_ready"}, in_ready, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sc;
        rst_n = 1;
        #2 rst_n = 0;
        #1 chk_reset_state("rst");
        repeat (2) @(negedge clk);
        #1 rst_n = 1;

        // E4M3 directed beat, scale 127
        clr_obs();
        q_blk(8'd127, 1'b0, {8'h7F, 8'h80, 8'h01, 8'h38}, 1);
        drain("t1");
        chk("t1_exp",  got[0].e, pe(0, -6, 0, 0));
        chk("t1_mant", got[0].m, 16'h0018);
        chk("t1_zero", got[0].z, 4'b0100);
        chk("t1_sign", got[0].s, 4'b0100);
        chk("t1_nan",  got[0].n, 4'b1000);
        chk("t1_latency", ofire_cyc[0] - fire_cyc[0], 1);

        // E5M2 directed beat, scale 130
        clr_obs();
        q_blk(8'd130, 1'b1, {8'h7D, 8'hFC, 8'h7C, 8'h3C}, 1);
        drain("t2");
        chk("t2_exp",  got[0].e, pe(3, 0, 0, 0));
        chk("t2_mant", got[0].m, 16'h0008);
        chk("t2_inf",  got[0].i, 4'b0110);
        chk("t2_nan",  got[0].n, 4'b1000);
        chk("t2_sign", got[0].s, 4'b0100);

        // Smallest scale on the smallest subnormal
        clr_obs();
        q_blk(8'h00, 1'b0, {4{8'h01}}, 0);
        drain("t3");
        chk("t3_exp",  got[0].e, pe(-133, -133, -133, -133));
        chk("t3_mant", got[0].m, 16'h1111);

        // NaN scale poisons the whole block
        clr_obs();
        q_blk(8'hFF, 1'b1, $urandom, 1);
        drain("t4");
        for (int k = 0; k < NB; k++) chk("t4_nan_all", got[k].n, 4'hF);
        chk("t4_last7", got[NB-1].last, 1);
        chk("t4_last6", got[NB-2].last, 0);

        // Back-to-back blocks: next scale accepted on the last beat, no bubble
        clr_obs();
        q_blk(8'd100, 1'b0, $urandom, 1);
        q_blk(8'd150, 1'b1, $urandom, 1);
        drain("t5");
        chk("t5_no_bubble", fire_cyc[2*NB-1] - fire_cyc[0], 2*NB - 1);
        chk("t5_scale_on_last", sfire_cyc[1], fire_cyc[NB-1]);
        chk("t5_in_ready_idle", in_ready, 0);
        chk("t5_scale_ready_idle", scale_ready, 1);

        // Output stall: data frozen, one beat buffered, input blocked
        clr_obs();
        q_blk(8'd120, 1'b1, $urandom, 1);
        q_blk(8'd140, 1'b0, $urandom, 1);
        wait_fires(2);
        bp_mode = 2;
        @(posedge clk);
        #2;
        snap = '{s: out_sign, z: out_zero, n: out_nan, i: out_inf,
                 e: out_exp, m: out_mant, last: out_last};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_exp", out_exp, snap.e);
            chk("hold_flags", {out_sign, out_mant, out_zero, out_nan, out_inf, out_last},
                {snap.s, snap.m, snap.z, snap.n, snap.i, snap.last});
        end
        bp_mode = 0;
        drain("t6");
        chk("t6_beats_out", got.size(), 2 * NB);

        // Asynchronous reset mid-block, then a fresh scale is required
        clr_obs();
        q_blk(8'd127, 1'b0, $urandom, 1);
        wait_fires(3);
        @(posedge clk);
        #3 rst_n = 0;
        sq.delete();
        bq.delete();
        #1 chk_reset_state("mid_rst");
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        for (int k = 0; k < NB; k++) bq.push_back($urandom);
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_in_ready", in_ready, 0);
            chk("post_rst_out_valid", out_valid, 0);
        end
        clr_obs();
        sq.push_back({1'b1, 8'd127});
        drain("t7");
        chk("t7_beats_out", got.size(), NB);

        // Random blocks with gaps and random back-pressure
        gaps = 1;
        bp_mode = 1;
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 5))
                0:       sc = 8'hFF;
                1:       sc = 8'h00;
                default: sc = 8'($urandom);
            endcase
            q_blk(sc, 1'($urandom_range(0, 1)), $urandom, 1);
        end
        drain("rand");
        gaps = 0;
        bp_mode = 0;

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
